// File: rtl/mem_scan_spi_master.sv
// mem_scan_spi_master: SPI mode-0 master issuing one 3-byte read (ADDR_HI, ADDR_LO, dummy) per address of a range.
// Optional data check against addr[7:0]^CHK_XOR is built when SCAN_CHECK_EN is defined.
module mem_scan_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int BYTE_GAP = 8,
  parameter int CS_GAP   = 4
`ifdef SCAN_CHECK_EN
  ,parameter logic [7:0] CHK_XOR = 8'hA5
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_addr_first,
  input  logic [15:0] i_addr_last,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_cs_n,
  input  logic        i_miso,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_rd_valid,
  output logic [15:0] o_rd_addr,
  output logic [7:0]  o_rd_byte
`ifdef SCAN_CHECK_EN
  ,output logic [15:0] o_err_count,
  output logic [15:0] o_first_err_addr,
  output logic        o_err
`endif
);
  localparam logic [2:0] S_IDLE = 3'd0, S_CHECK = 3'd1, S_SETUP = 3'd2, S_SHIFT = 3'd3,
                         S_BGAP = 3'd4, S_HOLD  = 3'd5, S_GAP   = 3'd6, S_DONE  = 3'd7;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] BG_M1  = 8'(BYTE_GAP - 1);
  localparam logic [7:0] CG_M1  = 8'(CS_GAP - 1);
  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_nx;
  logic [4:0]  bit_q, bit_d;
  logic [16:0] cur_q, cur_d;
  logic [15:0] last_q, last_d;
  logic [23:0] sh_q, sh_d;
  logic [7:0]  rx_q, rx_d;
  logic        sck_q, sck_d, cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d, rdv_q, rdv_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic [1:0]  miso_q;
  logic        cnt_hit, start_ok;
  assign cnt_hit  = cnt_q == ((state_q == S_BGAP) ? BG_M1 : (state_q == S_GAP) ? CG_M1 : DIV_M1);
  assign cnt_nx   = cnt_hit ? 8'd0 : cnt_q + 8'd1;
  // a start landing in the o_done cycle is dropped along with any start that coincides with abort
  assign start_ok = i_start && !i_abort && !done_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = 8'd0;
    bit_d     = bit_q;
    cur_d     = cur_q;
    last_d    = last_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdv_d     = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_byte_d = rd_byte_q;
    case (state_q)
      S_IDLE: if (start_ok) begin
        cur_d   = {1'b0, i_addr_first};
        last_d  = i_addr_last;
        busy_d  = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: if (cur_q > {1'b0, last_q}) state_d = S_DONE;
      else begin
        state_d = S_SETUP;
        cs_n_d  = 1'b0;
        sh_d    = {cur_q[15:0], 8'h00};
        bit_d   = 5'd0;
      end
      S_SETUP: begin
        cnt_d = cnt_nx;
        if (cnt_hit) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_nx;
        if (cnt_hit) begin
          sck_d = !sck_q;
          if (!sck_q) rx_d = {rx_q[6:0], miso_q[1]};
          else begin
            sh_d  = {sh_q[22:0], 1'b0};
            bit_d = bit_q + 5'd1;
            if (bit_q[2:0] == 3'd7) state_d = (bit_q == 5'd23) ? S_HOLD : S_BGAP;
          end
        end
      end
      S_BGAP: begin
        cnt_d = cnt_nx;
        if (cnt_hit) state_d = S_SHIFT;
      end
      S_HOLD: begin
        cnt_d = cnt_nx;
        if (cnt_hit) begin
          cs_n_d    = 1'b1;
          rdv_d     = 1'b1;
          rd_addr_d = cur_q[15:0];
          rd_byte_d = rx_q;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_nx;
        if (cnt_hit) begin
          cur_d   = cur_q + 17'd1;
          state_d = S_CHECK;
        end
      end
      default: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    if (i_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      bit_d   = 5'd0;
      sh_d    = 24'd0;
      sck_d   = 1'b0;
      cs_n_d  = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rdv_d   = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 5'd0;
      cur_q     <= 17'd0;
      last_q    <= 16'd0;
      sh_q      <= 24'd0;
      rx_q      <= 8'd0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdv_q     <= 1'b0;
      rd_addr_q <= 16'd0;
      rd_byte_q <= 8'd0;
      miso_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdv_q     <= rdv_d;
      rd_addr_q <= rd_addr_d;
      rd_byte_q <= rd_byte_d;
      miso_q    <= {miso_q[0], i_miso};
    end
  end
  assign o_sck      = sck_q;
  assign o_mosi     = sh_q[23];
  assign o_cs_n     = cs_n_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rd_valid = rdv_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_byte  = rd_byte_q;
`ifdef SCAN_CHECK_EN
  logic [15:0] err_cnt_q, first_err_q;
  logic        err_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q   <= 16'd0;
      first_err_q <= 16'd0;
      err_q       <= 1'b0;
    end else if (state_q == S_IDLE && start_ok) begin
      err_cnt_q   <= 16'd0;
      first_err_q <= 16'd0;
      err_q       <= 1'b0;
    end else if (rdv_q && rd_byte_q != (rd_addr_q[7:0] ^ CHK_XOR)) begin
      err_cnt_q <= (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      if (!err_q) begin
        err_q       <= 1'b1;
        first_err_q <= rd_addr_q;
      end
    end
  end
  assign o_err_count      = err_cnt_q;
  assign o_first_err_addr = first_err_q;
  assign o_err            = err_q;
`endif
endmodule

// File: doc/mem_scan_spi_master.md
Name: mem_scan_spi_master

Overview:
- Tester-side SPI master that drives the memory-test SPI slave port (i_sck/i_mosi/i_cs/o_miso) from upstream.
- Walks an address range and issues one 3-byte read transaction per address: ADDR_HI, ADDR_LO, dummy 0x00.
- Streams each returned byte out with its address, for self-test benches and on-board loopback scans.

Parameters:
- CLK_DIV, 4, i_clk cycles per SCK half-period; legal range 4..255 so the slave oversamples SCK.
- BYTE_GAP, 8, i_clk cycles with SCK low between bytes; gives the slave FSM time to map the address and load tx data.
- CS_GAP, 4, minimum i_clk cycles with o_cs_n high between transactions.
- CHK_XOR, 8'hA5, expected-data pattern, used only with SCAN_CHECK_EN.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; starts a scan when idle, ignored while busy
- i_abort  in  1  terminate scan at next cycle
- i_addr_first  in  16  first address; sampled on accepted i_start
- i_addr_last  in  16  last address, inclusive; sampled on accepted i_start
- o_sck  out  1  SPI clock, mode 0, idles low
- o_mosi  out  1  SPI data out, MSB first
- o_cs_n  out  1  SPI chip select, active low
- i_miso  in  1  SPI data in; passed through a 2-flop synchroniser
- o_busy  out  1  high from accepted start until DONE/abort completes
- o_done  out  1  one-cycle pulse at normal scan completion
- o_rd_valid  out  1  one-cycle pulse; o_rd_addr/o_rd_byte valid
- o_rd_addr  out  16  address of returned byte
- o_rd_byte  out  8  byte returned during dummy byte

Behaviour:
- Reset (async, i_rst_n=0): o_cs_n=1, o_sck=0, o_mosi=0, o_busy=0, o_done=0, o_rd_valid=0, o_rd_addr=0, o_rd_byte=0, state IDLE, counters 0. Applies immediately, including mid-transaction.
- States and transitions:
  - IDLE: on i_start, latch the range, set o_busy=1 next cycle, go to CHECK.
  - CHECK: if cur > last (17-bit compare), go to DONE; else go to CS_SETUP.
  - CS_SETUP: o_cs_n=0 for CLK_DIV cycles; o_mosi holds bit 23 of the shift word {cur, 8'h00}.
  - SHIFT: 8 SCK periods per byte. SCK rises after CLK_DIV cycles low. i_miso (synchronised) is sampled on the rising edge. o_mosi updates on the falling edge.
  - BGAP: between bytes 1-2 and 2-3, SCK low for BYTE_GAP cycles.
  - CS_HOLD: SCK low for CLK_DIV cycles, then o_cs_n=1.
  - GAP: CS_GAP cycles, then cur+1 and return to CHECK.
  - DONE: o_done=1 for one cycle, o_busy=0 in the same cycle, then IDLE.
- Transaction length with CLK_DIV=4, BYTE_GAP=8: 4+3*64+2*8+4 = 216 cycles with o_cs_n low.
- o_rd_valid pulses in the first cycle o_cs_n=1 after a completed transaction.
  - o_rd_byte = bits sampled during byte 3, MSB first.
  - o_rd_addr = address of that transaction.
  - Both registers hold their value until the next o_rd_valid.
- Bits sampled during bytes 1-2 are discarded.
- Range rules:
  - addr_first > addr_last: no CS activity; o_done pulses 3 cycles after i_start.
  - addr_last = 16'hFFFF: scan ends after 0xFFFF with no wrap (17-bit counter).
  - addr_first = addr_last: exactly one transaction.
- i_abort:
  - Next cycle: o_cs_n=1, o_sck=0, o_mosi=0. No o_rd_valid for the partial transaction; o_done not asserted; o_busy=0; state IDLE.
  - Abort wins over a simultaneous i_start.
  - Abort in IDLE has no effect.
- i_start while o_busy is ignored. i_start in the same cycle as o_done is ignored.

Optional Feature:
- Macro: SCAN_CHECK_EN.
- Defined:
  - Extra ports: o_err_count (out, 16, saturating at 16'hFFFF), o_first_err_addr (out, 16), o_err (out, 1, sticky).
  - On each o_rd_valid, compare o_rd_byte against (o_rd_addr[7:0] ^ CHK_XOR). On mismatch, increment o_err_count.
  - On the first mismatch, capture o_first_err_addr and set o_err.
  - All three clear on reset and on accepted i_start.
- Undefined: the ports do not exist; there is no compare logic.

Test Plan:
- Slave model returns addr[7:0]^8'hA5; start with first=0x0010, last=0x0013 -> 4 rd_valid pulses, bytes 0xB5,0xB4,0xB7,0xB6; o_done once; o_cs_n low for 216 cycles per transaction; MOSI bytes 00,10,00 on the first transaction.
- first=0x0005, last=0x0004 -> no o_cs_n low, no rd_valid, o_done pulses 3 cycles after i_start.
- first=last=0xFFFF -> one transaction with MOSI FF,FF,00, then done; no wrap to 0x0000.
- i_abort asserted during byte 2 of the second transaction -> o_cs_n=1 and o_sck=0 next cycle, 1 rd_valid total, no o_done, o_busy=0.
- Second i_start pulsed mid-scan -> ignored; range and rd_valid count unchanged. i_rst_n low mid-SHIFT -> all outputs at reset values within the same cycle.
- SCAN_CHECK_EN: slave corrupts 0x0012 to 0x00 in the range 0x0010..0x0013 -> o_err_count=1, o_first_err_addr=0x0012, o_err=1; a new i_start clears all three.
